mdu_iter: RTL and testbench
===========================

# mdu_iter

Iterative multiply/divide unit for the execute stage of the PPC core. It computes mullw, mulhw, mulhwu, divw and divwu one bit per cycle using a counter-driven FSM. It raises busy so the hazard logic can stall the pipeline, and pulses done when the result is ready. Its registered result is one data input of the execute-result / writeback select mux.

## Interface
- WIDTH, 32, operand and result width; must be even and ≥ 4.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  request; sampled on the rising edge.
- op  in  3  operation: 000 mullw, 001 mulhw, 010 mulhwu, 100 divw, 101 divwu. Other codes are illegal.
- a  in  WIDTH  rA operand (dividend / multiplicand); sampled only on start acceptance.
- b  in  WIDTH  rB operand (divisor / multiplier); sampled only on start acceptance.
- busy  out  1  high while the unit is computing.
- done  out  1  one-cycle pulse; result valid.
- result  out  WIDTH  registered result; held until the next accepted start.
- ov  out  1  high together with done for divide-by-zero or signed divide overflow.

## Operation
- FSM states: IDLE, CALC, FIX, FIN.
  - busy = (CALC or FIX).
  - done = FIN (Moore output).
- Start acceptance: start=1 with a legal op in IDLE or FIN is accepted.
  - start during CALC/FIX is ignored.
  - start with an illegal op is ignored in every state.
- On acceptance:
  - Latch op and the signed-ness flag.
  - Latch |a| and |b| (signed ops take the two's-complement magnitude; unsigned ops use the raw value).
  - Record sign = a[MSB] ^ b[MSB] for signed ops.
  - Load count = WIDTH-1, clear ov, go to CALC.
- Special-case bypass, checked at acceptance:
  - divw/divwu with b=0 → FIN, result=0, ov=1.
  - divw with a=0x80000000 and b=all-ones → FIN, result=0, ov=1.
  - No CALC cycles are spent in either case.
- CALC, multiply: shift-add over a 2·WIDTH product register, one multiplier bit per cycle.
- CALC, divide: restoring division, one quotient bit per cycle. The remainder is discarded.
- CALC exit: count decrements each cycle; at count=0 the next state is FIX.
- FIX:
  - If the signed op has sign=1, negate the 2·WIDTH product or the WIDTH quotient. Signed division truncates toward zero.
  - Select result: mullw = product[WIDTH-1:0]; mulhw/mulhwu = product[2·WIDTH-1:WIDTH]; divide = quotient.
  - Write result to the register, then go to FIN.
- FIN: done=1 for exactly one cycle. Next state is IDLE, or CALC/FIN if a new start is accepted.
- mullw low half is identical for signed and unsigned; it is computed with the signed path.
- Reset (any time, including mid-operation):
  - State → IDLE; busy=0, done=0, ov=0, result=0, counter=0.
  - The in-flight operation is discarded with no done.

## Timing
- Cycle numbering: start is high in cycle 0 and accepted at the end of cycle 0.
- Normal latency:
  - CALC occupies cycles 1..WIDTH.
  - FIX is cycle WIDTH+1.
  - done is high in cycle WIDTH+2 only.
  - For WIDTH=32: busy in cycles 1–33, done in cycle 34.
- Bypass latency: done and ov are high in cycle 1; busy stays 0.
- result changes only on the FIX→FIN edge or the bypass edge. It is stable during done and afterwards.
- Back-to-back: start in the FIN cycle is accepted; the next done comes WIDTH+2 cycles later. There is no idle bubble.
- Reset is asynchronous: outputs go to 0 without waiting for a clk edge.

## Test plan
- mullw a=7, b=0xFFFFFFFD (WIDTH=32) → busy cycles 1–33, done only in cycle 34, result=0xFFFFFFEB, ov=0.
- Multiply-high cases:
  - mulhw a=b=0x80000000 → result=0x40000000.
  - mulhwu a=b=0xFFFFFFFF → result=0xFFFFFFFE.
  - mulhw a=0xFFFFFFFF, b=1 → result=0xFFFFFFFF.
- Divide cases:
  - divw a=0xFFFFFFF9 (−7), b=2 → result=0xFFFFFFFD (−3).
  - divwu a=0xFFFFFFFF, b=0x10 → 0x0FFFFFFF.
  - divw a=7, b=0xFFFFFFFE → 0xFFFFFFFD.
- Bypass cases:
  - divwu a=5, b=0 → done and ov in cycle 1, result=0, busy never high.
  - divw a=0x80000000, b=0xFFFFFFFF → same response.
- Start filtering:
  - start pulse during cycle 10 of a busy operation → ignored; the original result is unchanged.
  - start op=011 in IDLE → ignored.
  - start in the FIN cycle → second done exactly 34 cycles later.
- Mid-operation reset:
  - rst asserted in cycle 12 of divw → busy/done/result/ov = 0 immediately (before the next edge), no done pulse.
  - After rst deasserts, mullw 3×4 → result=12 in cycle 34.

Source files
------------

// File: rtl/mdu_iter.sv
// mdu_iter: iterative multiply/divide unit that handles mullw/mulhw/mulhwu/divw/divwu one bit per cycle.
// Operands are reduced to magnitudes at acceptance; the FIX state restores the sign of the product or quotient.
module mdu_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             ov
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [2:0] OP_MULLW  = 3'b000;
    localparam logic [2:0] OP_MULHW  = 3'b001;
    localparam logic [2:0] OP_MULHWU = 3'b010;
    localparam logic [2:0] OP_DIVW   = 3'b100;
    localparam logic [2:0] OP_DIVWU  = 3'b101;
    typedef enum logic [1:0] {IDLE, CALC, FIX, FIN} state_t;
    state_t               r_state;
    logic [2:0]           r_op;
    logic                 r_neg;
    logic                 r_ov;
    logic [CW-1:0]        r_cnt;
    logic [WIDTH-1:0]     r_opnd;
    logic [WIDTH-1:0]     r_result;
    logic [2*WIDTH-1:0]   r_prod;
    logic                 w_legal;
    logic                 w_signed;
    logic                 w_accept;
    logic                 w_byp;
    logic [WIDTH-1:0]     w_abs_a;
    logic [WIDTH-1:0]     w_abs_b;
    logic [WIDTH:0]       w_sum;
    logic [WIDTH:0]       w_trial;
    logic [2*WIDTH-1:0]   w_step;
    logic [2*WIDTH-1:0]   w_fixed;
    logic [WIDTH-1:0]     w_res;
    assign w_legal  = op inside {OP_MULLW, OP_MULHW, OP_MULHWU, OP_DIVW, OP_DIVWU};
    assign w_signed = op inside {OP_MULLW, OP_MULHW, OP_DIVW};
    assign w_accept = start && w_legal && (r_state == IDLE || r_state == FIN);
    assign w_abs_a  = (w_signed && a[WIDTH-1]) ? -a : a;
    assign w_abs_b  = (w_signed && b[WIDTH-1]) ? -b : b;
    assign w_byp    = op[2] && (b == '0 || (op == OP_DIVW && a == {1'b1, {(WIDTH-1){1'b0}}} && b == '1));
    // Multiply: r_prod = {partial sum, remaining multiplier}; divide: r_prod = {remainder, dividend/quotient}.
    assign w_sum    = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + (r_prod[0] ? {1'b0, r_opnd} : '0);
    assign w_trial  = r_prod[2*WIDTH-1:WIDTH-1] - {1'b0, r_opnd};
    assign w_step   = !r_op[2] ? {w_sum, r_prod[WIDTH-1:1]} :
                      w_trial[WIDTH] ? {r_prod[2*WIDTH-2:0], 1'b0} :
                      {w_trial[WIDTH-1:0], r_prod[WIDTH-2:0], 1'b1};
    assign w_fixed  = r_neg ? -r_prod : r_prod;
    assign w_res    = (r_op == OP_MULLW || r_op[2]) ? w_fixed[WIDTH-1:0] : w_fixed[2*WIDTH-1:WIDTH];
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_op     <= '0;
            r_neg    <= 1'b0;
            r_ov     <= 1'b0;
            r_cnt    <= '0;
            r_opnd   <= '0;
            r_result <= '0;
            r_prod   <= '0;
        end else if (w_accept) begin
            r_op     <= op;
            r_neg    <= w_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
            r_opnd   <= op[2] ? w_abs_b : w_abs_a;
            r_prod   <= {{WIDTH{1'b0}}, op[2] ? w_abs_a : w_abs_b};
            r_cnt    <= CW'(WIDTH - 1);
            r_ov     <= w_byp;
            r_result <= w_byp ? '0 : r_result;
            r_state  <= w_byp ? FIN : CALC;
        end else if (r_state == CALC) begin
            r_prod  <= w_step;
            r_cnt   <= r_cnt - 1'b1;
            r_state <= (r_cnt == '0) ? FIX : CALC;
        end else if (r_state == FIX) begin
            r_result <= w_res;
            r_state  <= FIN;
        end else if (r_state == FIN) begin
            r_ov    <= 1'b0;
            r_state <= IDLE;
        end
    end
    assign busy   = (r_state == CALC) || (r_state == FIX);
    assign done   = (r_state == FIN);
    assign result = r_result;
    assign ov     = r_ov;
endmodule

// File: tb/tb_mdu_iter.sv
// tb_mdu_iter: directed checks of mdu_iter latency, results, bypass, start filtering and async reset.
module tb_mdu_iter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op = 3'b000;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        busy, done, ov;
    logic [31:0] result;
    int n_chk = 0;
    int n_fail = 0;
    mdu_iter #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .result(result), .ov(ov)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask
    // Leaves the caller at the negedge inside cycle 1 of the request.
    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(negedge clk);
        start = 1'b0;
    endtask
    // Walks from cycle c0 until done, checking busy each cycle, the done cycle, result and ov.
    task automatic wait_done(input string tag, input int c0, input int lat, input logic [31:0] er, input logic eo);
        int dc = -1;
        logic bad_busy = 1'b0;
        for (int c = c0; c <= lat + 4 && dc < 0; c++) begin
            if (c > c0) @(negedge clk);
            if (busy !== (c < lat)) bad_busy = 1'b1;
            if (done === 1'b1) dc = c;
        end
        check({tag, " done_cycle"}, dc, lat);
        check({tag, " busy_pattern"}, {31'b0, bad_busy}, 32'd0);
        check({tag, " result"}, result, er);
        check({tag, " ov"}, {31'b0, ov}, {31'b0, eo});
    endtask
    initial begin
        @(negedge clk);
        check("reset busy", {31'b0, busy}, 0);
        check("reset done", {31'b0, done}, 0);
        check("reset result", result, 0);
        check("reset ov", {31'b0, ov}, 0);
        @(negedge clk);
        rst = 1'b0;
        issue(3'b011, 32'd1, 32'd2);
        check("illegal busy", {31'b0, busy}, 0);
        @(negedge clk);
        check("illegal done", {31'b0, done}, 0);
        issue(3'b000, 32'd7, 32'hFFFF_FFFD);
        wait_done("mullw", 1, 34, 32'hFFFF_FFEB, 1'b0);
        @(negedge clk);
        check("mullw done_one_cycle", {31'b0, done}, 0);
        check("mullw result_held", result, 32'hFFFF_FFEB);
        issue(3'b001, 32'h8000_0000, 32'h8000_0000);
        wait_done("mulhw_min", 1, 34, 32'h4000_0000, 1'b0);
        issue(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done("mulhwu_max", 1, 34, 32'hFFFF_FFFE, 1'b0);
        issue(3'b001, 32'hFFFF_FFFF, 32'd1);
        wait_done("mulhw_neg1", 1, 34, 32'hFFFF_FFFF, 1'b0);
        issue(3'b100, 32'hFFFF_FFF9, 32'd2);
        wait_done("divw_neg7", 1, 34, 32'hFFFF_FFFD, 1'b0);
        issue(3'b101, 32'hFFFF_FFFF, 32'h10);
        wait_done("divwu", 1, 34, 32'h0FFF_FFFF, 1'b0);
        issue(3'b101, 32'd5, 32'd0);
        wait_done("divwu_by0", 1, 1, 32'd0, 1'b1);
        @(negedge clk);
        check("by0 ov_drop", {31'b0, ov}, 0);
        check("by0 done_drop", {31'b0, done}, 0);
        issue(3'b100, 32'd7, 32'hFFFF_FFFE);
        wait_done("divw_negdiv", 1, 34, 32'hFFFF_FFFD, 1'b0);
        issue(3'b100, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done("divw_ovf", 1, 1, 32'd0, 1'b1);
        issue(3'b000, 32'd3, 32'd5);
        repeat (9) @(negedge clk);
        start = 1'b1; op = 3'b101; a = 32'd100; b = 32'd0;
        @(negedge clk);
        start = 1'b0;
        wait_done("busy_start", 11, 34, 32'd15, 1'b0);
        issue(3'b000, 32'd6, 32'd7);
        wait_done("b2b_first", 1, 34, 32'd42, 1'b0);
        start = 1'b1; op = 3'b101; a = 32'd100; b = 32'd7;
        @(negedge clk);
        start = 1'b0;
        wait_done("b2b_second", 1, 34, 32'd14, 1'b0);
        issue(3'b100, 32'd1000, 32'd3);
        repeat (11) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check("midrst busy", {31'b0, busy}, 0);
        check("midrst done", {31'b0, done}, 0);
        check("midrst result", result, 0);
        check("midrst ov", {31'b0, ov}, 0);
        @(negedge clk);
        rst = 1'b0;
        begin
            int nd = 0;
            for (int i = 0; i < 40; i++) begin
                @(negedge clk);
                if (done !== 1'b0) nd++;
            end
            check("midrst no_done", nd, 0);
        end
        issue(3'b000, 32'd3, 32'd4);
        wait_done("after_rst", 1, 34, 32'd12, 1'b0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
